// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC fetch over a req/gnt/rvalid imem port, buffering words in a DEPTH-entry queue.
// Build option FETCHQ_BYPASS_EN: forward a response straight to Decode when the queue is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus8F,
  output logic        InstrValidF
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW        = $clog2(DEPTH + 1);
  localparam int          OW        = $clog2(MAX_OUT + 1);
  localparam logic [31:0] DEPTH_U   = DEPTH;
  localparam logic [31:0] MAX_OUT_U = MAX_OUT;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_discard;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];

  logic [31:0] w_credit;
  logic        w_rsp;
  logic        w_accept;
  logic        w_drop;
  logic        w_keep;
  logic        w_head_valid;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;

  // Slots already committed: queued words plus responses that will actually be kept.
  assign w_credit = 32'(r_count) + 32'(r_outstanding) - 32'(r_discard);

  assign imem_req  = !reset && !PCSrc && (32'(r_outstanding) < MAX_OUT_U) && (w_credit < DEPTH_U);
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp        = imem_rvalid && (r_outstanding != '0);
  assign w_drop       = w_rsp && (r_discard != '0);
  assign w_keep       = w_rsp && (r_discard == '0) && !PCSrc;
  assign w_head_valid = (r_count != '0);

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass = !reset && !w_head_valid && w_keep && !StallD;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_keep && !w_bypass;
  assign w_pop  = w_head_valid && !StallD && !PCSrc;

  always_comb begin
    InstrF      = '0;
    PCF         = '0;
    InstrValidF = 1'b0;
    if (w_head_valid) begin
      InstrF      = r_mem_instr[r_head];
      PCF         = r_mem_pc[r_head];
      InstrValidF = 1'b1;
    end else if (w_bypass) begin
      InstrF      = imem_rdata;
      PCF         = r_resp_pc;
      InstrValidF = 1'b1;
    end
    PCPlus8F = InstrValidF ? (PCF + 32'd8) : '0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_tail] <= imem_rdata;
      r_mem_pc[r_tail]    <= r_resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else if (PCSrc) begin
      // No request is issued in a redirect cycle, so only a response can retire here.
      r_fetch_pc    <= PCTarget & 32'hFFFF_FFFC;
      r_resp_pc     <= PCTarget & 32'hFFFF_FFFC;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_outstanding <= r_outstanding - OW'(w_rsp);
      r_discard     <= r_outstanding - OW'(w_rsp);
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_outstanding <= r_outstanding + OW'(w_accept) - OW'(w_rsp);
      if (w_drop) begin
        r_discard <= r_discard - 1'b1;
      end
      if (w_keep) begin
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios for fetch_queue against an in-order, fixed-latency memory model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        StallD = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrF, PCF, PCPlus8F;
  logic        InstrValidF;

  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic [31:0] InstrF2, PCF2, PCPlus8F2;
  logic        valid2;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int lat    = 1;
  bit hold   = 1'b0;

  typedef struct { logic [31:0] addr; int cnt; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] pc8; int cyc; } pop_t;
  pend_t       pend[$];
  pop_t        pops[$];
  pop_t        pops2[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];

  fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .StallD(StallD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .PCPlus8F(PCPlus8F), .InstrValidF(InstrValidF)
  );

  fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .StallD(StallD),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .InstrF(InstrF2), .PCF(PCF2), .PCPlus8F(PCPlus8F2), .InstrValidF(valid2)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: answers each grant after 'lat' cycles, in order; 'hold' withholds responses.
  initial begin
    logic        s_rst, s_acc, s_rv, s_acc2;
    logic [31:0] s_addr, s_addr2;
    forever begin
      @(posedge clk);
      s_rst = reset; s_acc = imem_req && imem_gnt; s_addr = imem_addr; s_rv = imem_rvalid;
      s_acc2 = req2; s_addr2 = addr2;
      #3;
      if (s_rst) begin
        pend.delete();
        imem_rvalid = 1'b0;
        rvalid2 = 1'b0;
      end else begin
        if (s_rv && pend.size() > 0) void'(pend.pop_front());
        foreach (pend[i]) if (pend[i].cnt > 0) pend[i].cnt--;
        if (s_acc) begin
          pend.push_back('{s_addr, lat - 1});
          acc_addr.push_back(s_addr);
          acc_cyc.push_back(cyc - 1);
        end
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!hold && pend.size() > 0) begin
          if (pend[0].cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
          end
        end
        rvalid2 = s_acc2;
        rdata2  = mem_word(s_addr2);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (InstrValidF === 1'b1 && StallD === 1'b0) pops.push_back('{PCF, InstrF, PCPlus8F, cyc});
    if (valid2 === 1'b1 && StallD === 1'b0) pops2.push_back('{PCF2, InstrF2, PCPlus8F2, cyc});
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs;
    pops.delete(); pops2.delete(); acc_addr.delete(); acc_cyc.delete();
  endtask

  task automatic do_reset;
    reset = 1'b1; PCSrc = 1'b0;
    step(2);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset;
    step(2);
    @(negedge clk);
    ntests++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    ntests++; if (InstrValidF !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", InstrValidF); end
    ntests++; if (InstrF !== 32'h0) begin nfail++; $display("FAIL reset_instr: got %h want 0", InstrF); end
    ntests++; if (PCF !== 32'h0) begin nfail++; $display("FAIL reset_pcf: got %h want 0", PCF); end
    ntests++; if (PCPlus8F !== 32'h0) begin nfail++; $display("FAIL reset_pc8: got %h want 0", PCPlus8F); end
    ntests++; if (imem_addr !== 32'h0) begin nfail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    ntests++; if (addr2 !== 32'hFFFF_FFF8) begin nfail++; $display("FAIL reset_addr_wrap: got %h want fffffff8", addr2); end
  endtask

  task automatic test_sequential;
    int exp_lat;
`ifdef FETCHQ_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    lat = 1; hold = 1'b0; imem_gnt = 1'b1; StallD = 1'b0;
    do_reset();
    step(12);
    ntests++;
    if (acc_addr.size() < 4) begin nfail++; $display("FAIL seq_grants: got %0d want >= 4", acc_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      ntests++; if (acc_addr[i] !== 32'(4 * i)) begin nfail++; $display("FAIL seq_addr%0d: got %h want %h", i, acc_addr[i], 32'(4 * i)); end
    end
    ntests++;
    if (pops.size() < 8) begin nfail++; $display("FAIL seq_pops: got %0d want >= 8", pops.size()); end
    else begin
      ntests++; if (pops[0].cyc !== acc_cyc[0] + exp_lat) begin nfail++; $display("FAIL seq_latency: got %0d want %0d", pops[0].cyc - acc_cyc[0], exp_lat); end
      for (int i = 0; i < 8; i++) begin
        ntests++; if (pops[i].pc !== 32'(4 * i)) begin nfail++; $display("FAIL seq_pc%0d: got %h want %h", i, pops[i].pc, 32'(4 * i)); end
        ntests++; if (pops[i].pc8 !== 32'(4 * i + 8)) begin nfail++; $display("FAIL seq_pc8_%0d: got %h want %h", i, pops[i].pc8, 32'(4 * i + 8)); end
        ntests++; if (pops[i].instr !== mem_word(32'(4 * i))) begin nfail++; $display("FAIL seq_instr%0d: got %h want %h", i, pops[i].instr, mem_word(32'(4 * i))); end
        if (i > 0) begin
          ntests++; if (pops[i].cyc !== pops[i-1].cyc + 1) begin nfail++; $display("FAIL seq_rate%0d: gap %0d want 1", i, pops[i].cyc - pops[i-1].cyc); end
        end
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] last;
    int          n;
    last = pops[pops.size() - 1].pc;
    n = pops.size();
    StallD = 1'b1;
    step(10);
    @(negedge clk);
    ntests++; if (InstrValidF !== 1'b1) begin nfail++; $display("FAIL stall_valid: got %b want 1", InstrValidF); end
    ntests++; if (PCF !== last + 32'd4) begin nfail++; $display("FAIL stall_head: got %h want %h", PCF, last + 32'd4); end
    ntests++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL stall_req_full: got %b want 0", imem_req); end
    ntests++; if (pops.size() !== n) begin nfail++; $display("FAIL stall_no_pop: got %0d want %0d", pops.size(), n); end
    step(1);
    StallD = 1'b0;
    step(12);
    ntests++;
    if (pops.size() < n + 8) begin nfail++; $display("FAIL drain_pops: got %0d want >= %0d", pops.size(), n + 8); end
    else for (int k = 0; k < 8; k++) begin
      ntests++; if (pops[n + k].pc !== last + 32'(4 * (k + 1))) begin nfail++; $display("FAIL drain_pc%0d: got %h want %h", k, pops[n + k].pc, last + 32'(4 * (k + 1))); end
    end
  endtask

  task automatic test_gnt_hold;
    lat = 1; hold = 1'b0; imem_gnt = 1'b0; StallD = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ntests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin nfail++; $display("FAIL gnt_hold%0d: got req %b addr %h want 1 0", i, imem_req, imem_addr); end
      step(1);
    end
    imem_gnt = 1'b1;
    step(6);
    ntests++;
    if (pops.size() < 2) begin nfail++; $display("FAIL gnt_hold_pops: got %0d want >= 2", pops.size()); end
    else begin
      ntests++; if (pops[0].pc !== 32'h0 || pops[1].pc !== 32'h4) begin nfail++; $display("FAIL gnt_hold_pcs: got %h %h want 0 4", pops[0].pc, pops[1].pc); end
    end
  endtask

  task automatic test_redirect;
    lat = 1; hold = 1'b1; imem_gnt = 1'b1; StallD = 1'b0;
    do_reset();
    step(2);
    @(negedge clk);
    ntests++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL redir_maxout: got %b want 0", imem_req); end
    step(1);
    PCSrc = 1'b1; PCTarget = 32'h0000_0103;
    @(negedge clk);
    ntests++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL redir_req: got %b want 0", imem_req); end
    step(1);
    PCSrc = 1'b0; hold = 1'b0;
    pops.delete();
    @(negedge clk);
    ntests++; if (imem_addr !== 32'h100) begin nfail++; $display("FAIL redir_addr: got %h want 100", imem_addr); end
    ntests++; if (InstrValidF !== 1'b0) begin nfail++; $display("FAIL redir_empty: got %b want 0", InstrValidF); end
    step(8);
    ntests++;
    if (pops.size() < 2) begin nfail++; $display("FAIL redir_pops: got %0d want >= 2", pops.size()); end
    else begin
      ntests++; if (pops[0].pc !== 32'h100) begin nfail++; $display("FAIL redir_pc0: got %h want 100", pops[0].pc); end
      ntests++; if (pops[0].instr !== mem_word(32'h100)) begin nfail++; $display("FAIL redir_instr0: got %h want %h", pops[0].instr, mem_word(32'h100)); end
      ntests++; if (pops[1].pc !== 32'h104) begin nfail++; $display("FAIL redir_pc1: got %h want 104", pops[1].pc); end
    end
  endtask

  task automatic test_back_to_back;
    lat = 1; hold = 1'b1; imem_gnt = 1'b1; StallD = 1'b0;
    do_reset();
    step(3);
    PCSrc = 1'b1; PCTarget = 32'h300;
    step(1);
    PCTarget = 32'h400;
    step(1);
    PCSrc = 1'b0; hold = 1'b0;
    pops.delete();
    @(negedge clk);
    ntests++; if (imem_addr !== 32'h400) begin nfail++; $display("FAIL b2b_addr: got %h want 400", imem_addr); end
    step(8);
    ntests++;
    if (pops.size() < 2) begin nfail++; $display("FAIL b2b_pops: got %0d want >= 2", pops.size()); end
    else begin
      ntests++; if (pops[0].pc !== 32'h400 || pops[1].pc !== 32'h404) begin nfail++; $display("FAIL b2b_pcs: got %h %h want 400 404", pops[0].pc, pops[1].pc); end
    end
  endtask

  task automatic test_redirect_pop;
    lat = 2; hold = 1'b0; imem_gnt = 1'b1; StallD = 1'b1;
    do_reset();
    step(5);
    PCSrc = 1'b1; PCTarget = 32'h200; StallD = 1'b0;
    @(negedge clk);
    ntests++; if (InstrValidF !== 1'b1) begin nfail++; $display("FAIL rpop_valid_before: got %b want 1", InstrValidF); end
    ntests++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL rpop_req: got %b want 0", imem_req); end
    step(1);
    PCSrc = 1'b0;
    pops.delete();
    @(negedge clk);
    ntests++; if (InstrValidF !== 1'b0) begin nfail++; $display("FAIL rpop_empty: got %b want 0", InstrValidF); end
    ntests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin nfail++; $display("FAIL rpop_issue: got req %b addr %h want 1 200", imem_req, imem_addr); end
    step(8);
    ntests++;
    if (pops.size() < 2) begin nfail++; $display("FAIL rpop_pops: got %0d want >= 2", pops.size()); end
    else begin
      ntests++; if (pops[0].pc !== 32'h200) begin nfail++; $display("FAIL rpop_pc0: got %h want 200", pops[0].pc); end
      ntests++; if (pops[1].pc !== 32'h204) begin nfail++; $display("FAIL rpop_pc1: got %h want 204", pops[1].pc); end
    end
  endtask

  task automatic test_wrap;
    lat = 1; hold = 1'b0; imem_gnt = 1'b1; StallD = 1'b0;
    do_reset();
    step(8);
    ntests++;
    if (pops2.size() < 3) begin nfail++; $display("FAIL wrap_pops: got %0d want >= 3", pops2.size()); end
    else begin
      ntests++; if (pops2[0].pc !== 32'hFFFF_FFF8 || pops2[0].pc8 !== 32'h0) begin nfail++; $display("FAIL wrap0: got %h/%h want fffffff8/0", pops2[0].pc, pops2[0].pc8); end
      ntests++; if (pops2[1].pc !== 32'hFFFF_FFFC || pops2[1].pc8 !== 32'h4) begin nfail++; $display("FAIL wrap1: got %h/%h want fffffffc/4", pops2[1].pc, pops2[1].pc8); end
      ntests++; if (pops2[2].pc !== 32'h0 || pops2[2].pc8 !== 32'h8) begin nfail++; $display("FAIL wrap2: got %h/%h want 0/8", pops2[2].pc, pops2[2].pc8); end
      ntests++; if (pops2[2].instr !== mem_word(32'h0)) begin nfail++; $display("FAIL wrap2_instr: got %h want %h", pops2[2].instr, mem_word(32'h0)); end
    end
  endtask

  task automatic test_mid_reset;
    lat = 1; hold = 1'b0; imem_gnt = 1'b1; StallD = 1'b1;
    do_reset();
    step(8);
    @(negedge clk);
    ntests++; if (InstrValidF !== 1'b1 || imem_req !== 1'b0) begin nfail++; $display("FAIL mreset_full: got valid %b req %b want 1 0", InstrValidF, imem_req); end
    step(1);
    reset = 1'b1;
    @(negedge clk);
    ntests++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL mreset_req_now: got %b want 0", imem_req); end
    step(1);
    @(negedge clk);
    ntests++; if (InstrValidF !== 1'b0) begin nfail++; $display("FAIL mreset_valid: got %b want 0", InstrValidF); end
    ntests++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL mreset_req: got %b want 0", imem_req); end
    ntests++; if (imem_addr !== 32'h0) begin nfail++; $display("FAIL mreset_addr: got %h want 0", imem_addr); end
    ntests++; if (PCF !== 32'h0 || InstrF !== 32'h0) begin nfail++; $display("FAIL mreset_outs: got %h %h want 0 0", PCF, InstrF); end
    step(1);
    reset = 1'b0; StallD = 1'b0;
    clear_logs();
    step(6);
    ntests++;
    if (pops.size() < 1) begin nfail++; $display("FAIL mreset_pops: got %0d want >= 1", pops.size()); end
    else begin
      ntests++; if (pops[0].pc !== 32'h0) begin nfail++; $display("FAIL mreset_pc0: got %h want 0", pops[0].pc); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_gnt_hold();
    test_redirect();
    test_back_to_back();
    test_redirect_pop();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
